// File: rtl/bsg_nonsynth_axi_mem.sv
// bsg_nonsynth_axi_mem: AXI4 slave backed by a simulation memory array.
// Define BSG_NONSYNTH_AXI_MEM_ERR_EN for SLVERR on out-of-range beats.
module bsg_nonsynth_axi_mem #(
  parameter int axi_id_width_p   = 6,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 64,
  parameter int axi_len_width_p  = 4,
  parameter int mem_els_p        = 1024,
  parameter logic [axi_data_width_p-1:0] init_data_p = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [axi_id_width_p-1:0]     axi_awid_i,
  input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
  input  logic [axi_len_width_p-1:0]    axi_awlen_i,
  input  logic [1:0]                    axi_awburst_i,
  input  logic                          axi_awvalid_i,
  output logic                          axi_awready_o,

  input  logic [axi_data_width_p-1:0]   axi_wdata_i,
  input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
  input  logic                          axi_wlast_i,
  input  logic                          axi_wvalid_i,
  output logic                          axi_wready_o,

  output logic [axi_id_width_p-1:0]     axi_bid_o,
  output logic [1:0]                    axi_bresp_o,
  output logic                          axi_bvalid_o,
  input  logic                          axi_bready_i,

  input  logic [axi_id_width_p-1:0]     axi_arid_i,
  input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
  input  logic [axi_len_width_p-1:0]    axi_arlen_i,
  input  logic [1:0]                    axi_arburst_i,
  input  logic                          axi_arvalid_i,
  output logic                          axi_arready_o,

  output logic [axi_id_width_p-1:0]     axi_rid_o,
  output logic [axi_data_width_p-1:0]   axi_rdata_o,
  output logic [1:0]                    axi_rresp_o,
  output logic                          axi_rlast_o,
  output logic                          axi_rvalid_o,
  input  logic                          axi_rready_i
);

  localparam int strb_lp  = axi_data_width_p / 8;
  localparam int lg_lp    = $clog2(strb_lp);
  localparam int idx_w_lp =
    (mem_els_p > 1) ? $clog2(mem_els_p) : 1;

`ifdef BSG_NONSYNTH_AXI_MEM_ERR_EN
  localparam bit err_en_lp = 1'b1;
`else
  localparam bit err_en_lp = 1'b0;
`endif

  localparam logic [1:0] okay_lp   = 2'b00;
  localparam logic [1:0] slverr_lp = 2'b10;

  typedef logic [axi_addr_width_p-1:0] addr_t;
  typedef logic [axi_data_width_p-1:0] data_t;
  typedef logic [idx_w_lp-1:0]         idx_t;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE, R_DATA
  } r_state_e;

  function automatic idx_t idx_of(addr_t a);
    addr_t w;
    w = a >> lg_lp;
    return idx_t'(w % addr_t'(mem_els_p));
  endfunction

  function automatic logic ok_of(addr_t a);
    addr_t w;
    w = a >> lg_lp;
    return !err_en_lp || (w < addr_t'(mem_els_p));
  endfunction

  function automatic addr_t next_addr(
    addr_t a, logic [1:0] burst
  );
    return (burst == 2'b00) ? a : a + addr_t'(strb_lp);
  endfunction

  // Contents survive reset; only time zero loads init_data_p.
  data_t mem_q [mem_els_p] = '{default: init_data_p};

  w_state_e                    w_state_q;
  logic                        awready_q, wready_q, bvalid_q;
  logic [axi_id_width_p-1:0]   awid_q;
  addr_t                       awaddr_q;
  logic [1:0]                  awburst_q, bresp_q;

  r_state_e                    r_state_q;
  logic                        arready_q, rvalid_q, rlast_q;
  logic [axi_id_width_p-1:0]   rid_q;
  addr_t                       araddr_q;
  logic [axi_len_width_p-1:0]  arlen_q, rcnt_q, rcnt_d;
  logic [1:0]                  arburst_q, rresp_q;
  data_t                       rdata_q;

  logic   w_ok, wr_en, r_ok;
  idx_t   w_idx, r_idx;
  addr_t  r_addr_d, r_addr_sel;
  data_t  r_word;

  // Burst length is taken from wlast alone.
  logic unused;
  assign unused = &{1'b0, axi_awlen_i};

  assign w_ok  = ok_of(awaddr_q);
  assign w_idx = idx_of(awaddr_q);
  assign wr_en = (w_state_q == W_DATA) & wready_q
               & axi_wvalid_i & w_ok;

  assign rcnt_d     = rcnt_q + 1'b1;
  assign r_addr_d   = next_addr(araddr_q, arburst_q);
  assign r_addr_sel = (r_state_q == R_IDLE)
                    ? axi_araddr_i : r_addr_d;
  assign r_ok   = ok_of(r_addr_sel);
  assign r_idx  = idx_of(r_addr_sel);
  assign r_word = r_ok ? mem_q[r_idx] : '0;

  // Byte-strobed write of the current beat into the array.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < strb_lp; b++) begin
        if (axi_wstrb_i[b])
          mem_q[w_idx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
      end
    end
  end

  // Write channel FSM: AW accept, W beats, B response.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= okay_lp;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awburst_q <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi_awvalid_i && awready_q) begin
            w_state_q <= W_DATA;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bresp_q   <= okay_lp;
            awid_q    <= axi_awid_i;
            awaddr_q  <= axi_awaddr_i;
            awburst_q <= axi_awburst_i;
          end
        end
        W_DATA: begin
          if (axi_wvalid_i) begin
            awaddr_q <= next_addr(awaddr_q, awburst_q);
            if (!w_ok)
              bresp_q <= slverr_lp;
            if (axi_wlast_i) begin
              w_state_q <= W_RESP;
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (axi_bready_i) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
          end
        end
        default: begin
          w_state_q <= W_IDLE;
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: AR accept, then one registered beat per rready.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= okay_lp;
      rid_q     <= '0;
      rdata_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arburst_q <= '0;
      rcnt_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (axi_arvalid_i && arready_q) begin
            r_state_q <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= axi_arid_i;
            araddr_q  <= axi_araddr_i;
            arlen_q   <= axi_arlen_i;
            arburst_q <= axi_arburst_i;
            rcnt_q    <= '0;
            rlast_q   <= (axi_arlen_i == '0);
            rdata_q   <= r_word;
            rresp_q   <= r_ok ? okay_lp : slverr_lp;
          end
        end
        R_DATA: begin
          if (axi_rready_i) begin
            if (rlast_q) begin
              r_state_q <= R_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= okay_lp;
              arready_q <= 1'b1;
            end else begin
              araddr_q <= r_addr_d;
              rcnt_q   <= rcnt_d;
              rlast_q  <= (rcnt_d == arlen_q);
              rdata_q  <= r_word;
              rresp_q  <= r_ok ? okay_lp : slverr_lp;
            end
          end
        end
        default: begin
          r_state_q <= R_IDLE;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign axi_awready_o = awready_q;
  assign axi_wready_o  = wready_q;
  assign axi_bvalid_o  = bvalid_q;
  assign axi_bid_o     = awid_q;
  assign axi_bresp_o   = bresp_q;

  assign axi_arready_o = arready_q;
  assign axi_rvalid_o  = rvalid_q;
  assign axi_rlast_o   = rlast_q;
  assign axi_rid_o     = rid_q;
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = rresp_q;

endmodule

// File: tb/tb_bsg_nonsynth_axi_mem.sv
// tb_bsg_nonsynth_axi_mem: directed and random AXI bursts
// against a word-array reference model.
`timescale 1ns/1ps
module tb_bsg_nonsynth_axi_mem;

  localparam logic [63:0] INIT = 64'hC0DE_0000_0000_BEEF;
  localparam int ELS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [5:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  bsg_nonsynth_axi_mem #(
    .init_data_p(INIT)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr),
    .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
    .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
    .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr),
    .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] mdl  [ELS];
  logic [63:0] wd_a [16];
  logic [7:0]  ws_a [16];

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_ok(logic [31:0] a);
`ifdef BSG_NONSYNTH_AXI_MEM_ERR_EN
    return (a >> 3) < ELS;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_idx(logic [31:0] a);
    return int'((a >> 3) % ELS);
  endfunction

  function automatic logic [63:0] m_rd(logic [31:0] a);
    return m_ok(a) ? mdl[m_idx(a)] : 64'h0;
  endfunction

  task automatic m_wr(
    input logic [31:0] a,
    input logic [63:0] d,
    input logic [7:0]  s
  );
    if (m_ok(a))
      for (int b = 0; b < 8; b++)
        if (s[b]) mdl[m_idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic aw_hs(
    input logic [5:0]  id,
    input logic [31:0] addr,
    input int          len,
    input logic [1:0]  burst
  );
    int n;
    awid = id; awaddr = addr;
    awlen = 4'(len); awburst = burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick; n++; end
    chk("aw_ready", awready, 1);
    tick;
    awvalid = 1'b0;
    chk("w_latency", wready, 1);
  endtask

  task automatic wr_burst(
    input logic [5:0]  id,
    input logic [31:0] addr,
    input int          len,
    input logic [1:0]  burst,
    input int          bdly
  );
    int n;
    logic [31:0] a;
    bit err;
    a = addr; err = 1'b0;
    aw_hs(id, addr, len, burst);
    for (int i = 0; i <= len; i++) begin
      wdata = wd_a[i]; wstrb = ws_a[i];
      wlast = (i == len); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 20) begin tick; n++; end
      chk("w_ready", wready, 1);
      if (!m_ok(a)) err = 1'b1;
      m_wr(a, wd_a[i], ws_a[i]);
      tick;
      if (burst != 2'b00) a += 32'd8;
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat (bdly) begin
      chk("b_hold", bvalid, 1);
      tick;
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin tick; n++; end
    chk("bvalid", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    tick;
    bready = 1'b0;
    chk("b_done", bvalid, 0);
  endtask

  task automatic rd_burst(
    input logic [5:0]  id,
    input logic [31:0] addr,
    input int          len,
    input logic [1:0]  burst,
    input int          stall
  );
    int n;
    logic [31:0] a;
    logic [63:0] exp;
    arid = id; araddr = addr;
    arlen = 4'(len); arburst = burst;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick; n++; end
    chk("ar_ready", arready, 1);
    tick;
    arvalid = 1'b0;
    chk("r_latency", rvalid, 1);
    a = addr;
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!rvalid && n < 20) begin tick; n++; end
      chk("rvalid", rvalid, 1);
      exp = m_rd(a);
      repeat (stall) begin
        chk("r_hold_data", rdata, exp);
        chk("r_hold_last", rlast, i == len);
        chk("r_hold_vld", rvalid, 1);
        tick;
      end
      chk("rdata", rdata, exp);
      chk("rid", rid, id);
      chk("rlast", rlast, i == len);
      chk("rresp", rresp, m_ok(a) ? 2'b00 : 2'b10);
      rready = 1'b1;
      tick;
      rready = 1'b0;
      if (burst != 2'b00) a += 32'd8;
    end
    chk("r_done", rvalid, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int len;
    logic [31:0] a;
    logic [1:0]  bt;

    for (int i = 0; i < ELS; i++) mdl[i] = INIT;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0;
    awvalid = 1'b0; wdata = '0; wstrb = '0;
    wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0;
    arvalid = 1'b0; rready = 1'b0;

    repeat (3) tick;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    rst = 1'b0;
    tick;
    chk("rel_awready", awready, 1);
    chk("rel_arready", arready, 1);
    chk("rel_bvalid", bvalid, 0);
    chk("rel_rvalid", rvalid, 0);

    for (int i = 0; i < 4; i++) begin
      wd_a[i] = 64'(8'h11 * (i + 1));
      ws_a[i] = 8'hFF;
    end
    wr_burst(6'd5, 32'h100, 3, 2'b01, 2);
    rd_burst(6'd7, 32'h100, 3, 2'b01, 0);

    wd_a[0] = '1; ws_a[0] = 8'hFF;
    wr_burst(6'd1, 32'h0, 0, 2'b01, 0);
    wd_a[0] = '0; ws_a[0] = 8'h0F;
    wr_burst(6'd1, 32'h0, 0, 2'b01, 0);
    rd_burst(6'd2, 32'h0, 0, 2'b01, 0);
    chk("strb_word", rdata, 64'hFFFF_FFFF_0000_0000);

    rd_burst(6'd3, 32'h100, 1, 2'b01, 3);

    wd_a[0] = 64'hA; wd_a[1] = 64'hB;
    ws_a[0] = 8'hFF; ws_a[1] = 8'hFF;
    wr_burst(6'd4, 32'h40, 1, 2'b00, 0);
    rd_burst(6'd4, 32'h40, 0, 2'b01, 0);
    chk("fixed_word", rdata, 64'hB);
    rd_burst(6'd4, 32'h48, 0, 2'b01, 0);
    chk("init_word", rdata, INIT);

    aw_hs(6'd9, 32'h200, 3, 2'b01);
    wdata = 64'h1111_2222; wstrb = 8'hFF;
    wlast = 1'b0; wvalid = 1'b1;
    m_wr(32'h200, wdata, wstrb);
    tick;
    wdata = 64'h3333_4444;
    rst = 1'b1;
    tick;
    tick;
    wvalid = 1'b0;
    chk("rstmid_bvalid", bvalid, 0);
    chk("rstmid_wready", wready, 0);
    rst = 1'b0;
    tick;
    chk("rstmid_awready", awready, 1);
    chk("rstmid_bvalid2", bvalid, 0);
    rd_burst(6'd9, 32'h200, 1, 2'b01, 0);
    wd_a[0] = 64'h55; ws_a[0] = 8'h3C;
    wr_burst(6'd10, 32'h208, 0, 2'b01, 1);
    rd_burst(6'd10, 32'h200, 1, 2'b01, 0);

    for (int t = 0; t < 60; t++) begin
      a = 32'($urandom_range(0, 2*ELS-1)) * 32'd8
        + 32'($urandom_range(0, 7));
      len = $urandom_range(0, 7);
      bt = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wd_a[i] = {$urandom, $urandom};
          ws_a[i] = 8'($urandom);
        end
        wr_burst(6'($urandom), a, len, bt,
                 $urandom_range(0, 2));
      end else begin
        rd_burst(6'($urandom), a, len, bt,
                 $urandom_range(0, 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
